instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch (IF) stage of the 16-bit pipelined core, directly upstream of instruction decode. It owns the program counter and drives the instruction-memory read handshake. It applies branch-predictor and execute-stage redirects, and loads the IF/ID pipeline register. That register supplies `instruction_if`, `next_program_counter_if` and the prediction bit to decode.

## Interface
- `RESET_VECTOR`, 16'h0000, PC value loaded on reset.
- `NOP_INSTR`, 16'h0000, instruction word driven on `instruction_if` when the slot is empty or flushed.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `address_to_memory`  out  16  word address of the current fetch; equals the PC register.
- `mem_req_if`  out  1  fetch request is valid.
- `data_from_memory`  in  16  instruction word; valid when `mem_ready` is high.
- `mem_ready`  in  1  request completes this cycle. Combinational same-cycle return is allowed.
- `target_bp`  in  16  predicted-taken target for the word completing this cycle.
- `target_en_bp`  in  1  predictor says taken for the word completing this cycle.
- `redirect_en_ex`  in  1  execute-stage mispredict/jump correction.
- `redirect_target_ex`  in  16  corrected PC.
- `stall_id`  in  1  decode cannot accept; hold the IF/ID register.
- `instruction_if`  out  16  IF/ID instruction.
- `next_program_counter_if`  out  16  IF/ID fall-through PC, equal to the fetch PC + 1.
- `pred_taken_if`  out  1  IF/ID prediction bit.
- `valid_if`  out  1  IF/ID slot holds a real instruction.

## Operation
- The PC is word addressed and increments by 1. Arithmetic is modulo 2^16, so 16'hFFFF + 1 = 16'h0000.
- States are BOOT, FETCH and HOLD.
  - BOOT: entered on reset. `mem_req_if` is 0. Moves to FETCH on the next edge.
  - FETCH: `mem_req_if` is 1 and `address_to_memory` = PC.
    - `mem_ready` = 0: stay in FETCH; the address holds stable.
    - `mem_ready` = 1 and `stall_id` = 0: the word, PC+1 and the prediction bit load into IF/ID, and `valid_if` goes to 1.
    - `mem_ready` = 1 and `stall_id` = 1: the same three values load into a one-entry skid buffer, and the state moves to HOLD.
    - In both completion cases the PC becomes `target_bp` if `target_en_bp` = 1, otherwise PC+1.
    - `mem_ready` = 0 and `stall_id` = 0: `valid_if` drops to 0 and `instruction_if` = `NOP_INSTR`.
  - HOLD: `mem_req_if` is 0. When `stall_id` drops, IF/ID is loaded from the skid buffer and the state returns to FETCH.
- IF/ID holds all fields unchanged whenever `stall_id` = 1.
- Priority within a cycle, highest first: `reset`, `redirect_en_ex`, `stall_id`, `target_en_bp`, sequential increment.
- Redirect (`redirect_en_ex` = 1), from any state other than BOOT:
  - PC becomes `redirect_target_ex`.
  - IF/ID is flushed: `valid_if` = 0, `instruction_if` = `NOP_INSTR`, `pred_taken_if` = 0.
  - The skid buffer is cleared.
  - Any completing or outstanding memory word is discarded.
  - The state becomes FETCH.
  - Memory requests are abortable, so changing the address while `mem_ready` = 0 is legal.
  - A redirect flushes IF/ID even when `stall_id` = 1.
- `target_en_bp` is ignored in any cycle where `mem_ready` = 0 or `mem_req_if` = 0.

## Timing
- Reset values:
  - PC = `RESET_VECTOR`, state = BOOT.
  - `valid_if` = 0, `instruction_if` = `NOP_INSTR`, `next_program_counter_if` = 0, `pred_taken_if` = 0.
  - `mem_req_if` = 0, skid buffer empty.
- `address_to_memory` and `mem_req_if` are driven directly from registers, with no combinational path from inputs.
- Latency with zero-wait memory: the word requested in cycle N is on `instruction_if` after edge N+1.
- Throughput is 1 instruction per cycle.
- Each memory wait cycle inserts one bubble (`valid_if` = 0).
- The first request is issued in the cycle after BOOT.
- Redirect penalty: the target address appears on `address_to_memory` in the cycle after `redirect_en_ex`, and IF/ID shows one flushed slot.
- Reset asserted mid-request: all state returns to reset values immediately; in-flight data is ignored.

## Configuration
- `IF_BRANCH_PREDICT_EN` defined: `target_en_bp`/`target_bp` redirect the PC as described above, and `pred_taken_if` reflects `target_en_bp` at completion.
- `IF_BRANCH_PREDICT_EN` undefined: the predictor inputs are ignored, the PC always advances by +1 on completion, and `pred_taken_if` is constant 0. Ports remain present.

## Test plan
- Reset, then zero-wait memory (`mem_ready` = 1): `address_to_memory` sequence 0,1,2,3. `instruction_if` follows one cycle behind with `next_program_counter_if` = 1,2,3 and `valid_if` = 1 from the second fetch cycle on.
- Two wait cycles on address 5: the address holds at 5 for three cycles, `valid_if` = 0 for two cycles, then the word arrives with `next_program_counter_if` = 6.
- At address 4, `target_en_bp` = 1 with `target_bp` = 32: the next address is 32, IF/ID shows `next_program_counter_if` = 5 and `pred_taken_if` = 1. Without the macro, the next address is 5 and `pred_taken_if` = 0.
- `stall_id` = 1 for 3 cycles while the word at 7 completes: IF/ID is unchanged, the state goes to HOLD with `mem_req_if` = 0. After release, the word at 7 appears, then fetch resumes at 8 with no instruction lost or duplicated.
- `redirect_en_ex` = 1 to 2 during a stalled HOLD: `valid_if` goes to 0, the skid is dropped, and the next address is 2.
- PC = 16'hFFFF completes: the next address is 0 and `next_program_counter_if` = 16'h0000.

Source files
------------

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - IF stage: PC, fetch handshake, redirects, IF/ID register
// Optional feature: define IF_BRANCH_PREDICT_EN to honour the branch-predictor target inputs.
module instruction_fetch #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter logic [15:0] NOP_INSTR    = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] address_to_memory,
    output logic        mem_req_if,
    input  logic [15:0] data_from_memory,
    input  logic        mem_ready,
    input  logic [15:0] target_bp,
    input  logic        target_en_bp,
    input  logic        redirect_en_ex,
    input  logic [15:0] redirect_target_ex,
    input  logic        stall_id,
    output logic [15:0] instruction_if,
    output logic [15:0] next_program_counter_if,
    output logic        pred_taken_if,
    output logic        valid_if
);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic        mem_req_q;
    logic [15:0] instr_q;
    logic [15:0] npc_q;
    logic        pred_q;
    logic        valid_q;
    logic [15:0] skid_instr_q;
    logic [15:0] skid_npc_q;
    logic        skid_pred_q;

    logic [15:0] pc_plus1_d;
    logic [15:0] pc_next_d;
    logic        take_bp_d;

    assign pc_plus1_d = pc_q + 16'd1;

`ifdef IF_BRANCH_PREDICT_EN
    assign take_bp_d = target_en_bp;
    assign pc_next_d = target_en_bp ? target_bp : pc_plus1_d;
`else
    logic bp_unused;
    assign bp_unused = ^{target_bp, target_en_bp};
    assign take_bp_d = 1'b0;
    assign pc_next_d = pc_plus1_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= BOOT;
            pc_q         <= RESET_VECTOR;
            mem_req_q    <= 1'b0;
            instr_q      <= NOP_INSTR;
            npc_q        <= 16'h0000;
            pred_q       <= 1'b0;
            valid_q      <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_npc_q   <= 16'h0000;
            skid_pred_q  <= 1'b0;
        end else if (redirect_en_ex && state_q != BOOT) begin
            // Abort any outstanding request and flush regardless of decode stall.
            state_q      <= FETCH;
            pc_q         <= redirect_target_ex;
            mem_req_q    <= 1'b1;
            instr_q      <= NOP_INSTR;
            pred_q       <= 1'b0;
            valid_q      <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_npc_q   <= 16'h0000;
            skid_pred_q  <= 1'b0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q   <= FETCH;
                    mem_req_q <= 1'b1;
                end
                FETCH: begin
                    if (mem_ready) begin
                        pc_q <= pc_next_d;
                        if (!stall_id) begin
                            instr_q <= data_from_memory;
                            npc_q   <= pc_plus1_d;
                            pred_q  <= take_bp_d;
                            valid_q <= 1'b1;
                        end else begin
                            skid_instr_q <= data_from_memory;
                            skid_npc_q   <= pc_plus1_d;
                            skid_pred_q  <= take_bp_d;
                            state_q      <= HOLD;
                            mem_req_q    <= 1'b0;
                        end
                    end else if (!stall_id) begin
                        instr_q <= NOP_INSTR;
                        pred_q  <= 1'b0;
                        valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_id) begin
                        instr_q   <= skid_instr_q;
                        npc_q     <= skid_npc_q;
                        pred_q    <= skid_pred_q;
                        valid_q   <= 1'b1;
                        state_q   <= FETCH;
                        mem_req_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= BOOT;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign address_to_memory       = pc_q;
    assign mem_req_if              = mem_req_q;
    assign instruction_if          = instr_q;
    assign next_program_counter_if = npc_q;
    assign pred_taken_if           = pred_q;
    assign valid_if                = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic [15:0] address_to_memory;
    logic        mem_req_if;
    logic [15:0] data_from_memory;
    logic        mem_ready;
    logic [15:0] target_bp;
    logic        target_en_bp;
    logic        redirect_en_ex;
    logic [15:0] redirect_target_ex;
    logic        stall_id;
    logic [15:0] instruction_if;
    logic [15:0] next_program_counter_if;
    logic        pred_taken_if;
    logic        valid_if;

    int tests;
    int fails;

    instruction_fetch dut (
        .clk                     (clk),
        .reset                   (reset),
        .address_to_memory       (address_to_memory),
        .mem_req_if              (mem_req_if),
        .data_from_memory        (data_from_memory),
        .mem_ready               (mem_ready),
        .target_bp               (target_bp),
        .target_en_bp            (target_en_bp),
        .redirect_en_ex          (redirect_en_ex),
        .redirect_target_ex      (redirect_target_ex),
        .stall_id                (stall_id),
        .instruction_if          (instruction_if),
        .next_program_counter_if (next_program_counter_if),
        .pred_taken_if           (pred_taken_if),
        .valid_if                (valid_if)
    );

    // Memory contents: each word is its address scrambled with a fixed pattern.
    assign data_from_memory = address_to_memory ^ 16'hA5A5;

    function automatic logic [15:0] word(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [15:0] ins,
                            input logic [15:0] npc, input logic pt);
        chk({tag, ".valid"}, {15'd0, valid_if}, {15'd0, v});
        chk({tag, ".instr"}, instruction_if, ins);
        chk({tag, ".npc"}, next_program_counter_if, npc);
        chk({tag, ".pred"}, {15'd0, pred_taken_if}, {15'd0, pt});
    endtask

    logic        exp_pred;
    logic [15:0] exp_bp_addr;

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        mem_ready = 1'b0;
        target_bp = 16'h0000;
        target_en_bp = 1'b0;
        redirect_en_ex = 1'b0;
        redirect_target_ex = 16'h0000;
        stall_id = 1'b0;
`ifdef IF_BRANCH_PREDICT_EN
        exp_pred = 1'b1;
        exp_bp_addr = 16'd32;
`else
        exp_pred = 1'b0;
        exp_bp_addr = 16'd5;
`endif

        repeat (2) step();
        chk("rst.addr", address_to_memory, 16'h0000);
        chk("rst.req", {15'd0, mem_req_if}, 16'd0);
        chk_ifid("rst", 1'b0, 16'h0000, 16'h0000, 1'b0);

        reset = 1'b0;
        step();
        chk("boot.req", {15'd0, mem_req_if}, 16'd1);
        chk("boot.addr", address_to_memory, 16'h0000);
        chk("boot.valid", {15'd0, valid_if}, 16'd0);

        // Zero-wait streaming
        mem_ready = 1'b1;
        step();
        chk("zw1.addr", address_to_memory, 16'd1);
        chk_ifid("zw1", 1'b1, word(16'd0), 16'd1, 1'b0);
        step();
        chk("zw2.addr", address_to_memory, 16'd2);
        chk_ifid("zw2", 1'b1, word(16'd1), 16'd2, 1'b0);
        step();
        chk("zw3.addr", address_to_memory, 16'd3);
        chk_ifid("zw3", 1'b1, word(16'd2), 16'd3, 1'b0);
        step();
        step();
        chk("zw5.addr", address_to_memory, 16'd5);
        chk("zw5.npc", next_program_counter_if, 16'd5);

        // Two wait cycles on address 5
        mem_ready = 1'b0;
        step();
        chk("w1.addr", address_to_memory, 16'd5);
        chk("w1.valid", {15'd0, valid_if}, 16'd0);
        chk("w1.instr", instruction_if, 16'h0000);
        step();
        chk("w2.addr", address_to_memory, 16'd5);
        chk("w2.valid", {15'd0, valid_if}, 16'd0);
        mem_ready = 1'b1;
        step();
        chk("w3.addr", address_to_memory, 16'd6);
        chk_ifid("w3", 1'b1, word(16'd5), 16'd6, 1'b0);

        // Redirect to 4, then predicted-taken at 4
        redirect_en_ex = 1'b1;
        redirect_target_ex = 16'd4;
        step();
        redirect_en_ex = 1'b0;
        chk("rd4.addr", address_to_memory, 16'd4);
        chk_ifid("rd4", 1'b0, 16'h0000, 16'd6, 1'b0);
        target_en_bp = 1'b1;
        target_bp = 16'd32;
        step();
        target_en_bp = 1'b0;
        chk("bp.addr", address_to_memory, exp_bp_addr);
        chk_ifid("bp", 1'b1, word(16'd4), 16'd5, exp_pred);

        // Decode stall while word 7 completes
        redirect_en_ex = 1'b1;
        redirect_target_ex = 16'd6;
        step();
        redirect_en_ex = 1'b0;
        chk("rd6.addr", address_to_memory, 16'd6);
        step();
        chk("s0.addr", address_to_memory, 16'd7);
        chk_ifid("s0", 1'b1, word(16'd6), 16'd7, 1'b0);
        stall_id = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st.req", {15'd0, mem_req_if}, 16'd0);
            chk("st.addr", address_to_memory, 16'd8);
            chk_ifid("st", 1'b1, word(16'd6), 16'd7, 1'b0);
        end
        stall_id = 1'b0;
        step();
        chk("rel.req", {15'd0, mem_req_if}, 16'd1);
        chk("rel.addr", address_to_memory, 16'd8);
        chk_ifid("rel", 1'b1, word(16'd7), 16'd8, 1'b0);
        step();
        chk("res.addr", address_to_memory, 16'd9);
        chk_ifid("res", 1'b1, word(16'd8), 16'd9, 1'b0);

        // Redirect while stalled in HOLD
        stall_id = 1'b1;
        step();
        chk("h.req", {15'd0, mem_req_if}, 16'd0);
        redirect_en_ex = 1'b1;
        redirect_target_ex = 16'd2;
        step();
        redirect_en_ex = 1'b0;
        chk("hr.addr", address_to_memory, 16'd2);
        chk("hr.req", {15'd0, mem_req_if}, 16'd1);
        chk("hr.valid", {15'd0, valid_if}, 16'd0);
        chk("hr.instr", instruction_if, 16'h0000);
        stall_id = 1'b0;
        step();
        chk("hr2.addr", address_to_memory, 16'd3);
        chk_ifid("hr2", 1'b1, word(16'd2), 16'd3, 1'b0);

        // PC wrap at 16'hFFFF
        redirect_en_ex = 1'b1;
        redirect_target_ex = 16'hFFFF;
        step();
        redirect_en_ex = 1'b0;
        chk("wr.addr", address_to_memory, 16'hFFFF);
        step();
        chk("wr2.addr", address_to_memory, 16'h0000);
        chk_ifid("wr2", 1'b1, word(16'hFFFF), 16'h0000, 1'b0);

        // Asynchronous reset mid-request
        mem_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("ar.req", {15'd0, mem_req_if}, 16'd0);
        chk("ar.addr", address_to_memory, 16'h0000);
        chk_ifid("ar", 1'b0, 16'h0000, 16'h0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
